// File: rtl/bicubic_load_scheduler.sv
// Frame-level scheduler for bicubic window loads: one request per 4-pixel quad, a line at a time.
// Optional BICUBIC_SCHED_STATS_EN adds a saturating stall-cycle counter output.
module bicubic_load_scheduler #(
    parameter int unsigned LOADS_PER_LINE = 320,
    parameter int unsigned LINES          = 180,
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned MAX_INFLIGHT   = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic        i_load_ready,
    input  logic        i_eol,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [8:0]  o_req_x,
    output logic [7:0]  o_req_y,
    output logic        o_busy,
    output logic        o_frame_done
`ifdef BICUBIC_SCHED_STATS_EN
    ,
    output logic [31:0] o_stall_cycles
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned SW = $clog2(SETTLE + 1);

    localparam logic [8:0]    X_LAST      = 9'(LOADS_PER_LINE - 1);
    localparam logic [7:0]    Y_LAST      = 8'(LINES - 1);
    localparam logic [IW-1:0] INFL_MAX    = IW'(MAX_INFLIGHT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    logic [2:0]    state_q, state_d;
    logic [8:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [SW-1:0] settle_q, settle_d;

    logic gate, grant, arm, dec;

    // The line gate is only looked at in ARM, so a line never starts half-way through the buffer.
    assign gate  = i_load_ready && (inflight_q < INFL_MAX);
    assign grant = valid_q && i_req_ready;
    assign arm   = (state_q == ST_ARM) && gate;
    assign dec   = i_eol && (inflight_q != '0);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_ARM;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_ARM: begin
                if (gate) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (grant) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            state_d = ST_DRAIN;
                        end else begin
                            y_d      = y_q + 8'd1;
                            settle_d = '0;
                            state_d  = ST_SETTLE;
                        end
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_ARM;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_comb begin
        inflight_d = inflight_q;
        if (arm && !dec) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!arm && dec) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            settle_q   <= settle_d;
        end
    end

    assign o_req_valid  = valid_q;
    assign o_req_x      = x_q;
    assign o_req_y      = y_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

`ifdef BICUBIC_SCHED_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_ev;

    assign stall_ev = ((state_q == ST_ARM) && !gate) || (valid_q && !i_req_ready);

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && i_start) begin
            stall_d = '0;
        end else if (stall_ev && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_bicubic_load_scheduler.sv
// Directed bench for bicubic_load_scheduler, run with a reduced line length and frame height.
// Connects o_stall_cycles when BICUBIC_SCHED_STATS_EN is defined.
module tb_bicubic_load_scheduler;

    localparam int P_LPL   = 40;
    localparam int P_LINES = 12;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       lr = 1'b0;
    logic       eol = 1'b0;
    logic       rr = 1'b0;
    logic       valid;
    logic [8:0] x;
    logic [7:0] y;
    logic       busy;
    logic       done;
`ifdef BICUBIC_SCHED_STATS_EN
    logic [31:0] stall;
`endif

    bicubic_load_scheduler #(
        .LOADS_PER_LINE (P_LPL),
        .LINES          (P_LINES),
        .SETTLE         (4),
        .MAX_INFLIGHT   (2)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_load_ready (lr),
        .i_eol        (eol),
        .o_req_valid  (valid),
        .i_req_ready  (rr),
        .o_req_x      (x),
        .o_req_y      (y),
        .o_busy       (busy),
        .o_frame_done (done)
`ifdef BICUBIC_SCHED_STATS_EN
        ,
        .o_stall_cycles (stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       lr;
        logic       eol;
        logic       rr;
        logic       valid;
        logic       busy;
        logic [8:0] x;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[11];
    int   tests = 0;
    int   fails = 0;

    int grants, seq_errs, hold_errs, dones, early, stalls_m, eols;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        start = 1'b0;
        eol = 1'b0;
        tick();
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_x"}, 32'(x), 0);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
`ifdef BICUBIC_SCHED_STATS_EN
        check({tag, "_stall"}, stall, 0);
`endif
        rstn = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Starts a frame and tracks every grant; EOL comes back a few cycles after each line's
    // last grant (later for the final line), so the line gate is never closed by inflight.
    task automatic run_frame(input bit rnd, input int stop_y, input int stop_x,
                             output bit stopped);
        int   exp_x, exp_y, eol_cd, post;
        logic pv;
        logic [8:0] px;
        logic [7:0] py;
        stopped = 1'b0;
        grants = 0; seq_errs = 0; hold_errs = 0; dones = 0; early = 0; stalls_m = 0; eols = 0;
        exp_x = 0; exp_y = 0; eol_cd = -1; post = -1;
        lr = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < P_LINES * (2 * P_LPL + 40) + 200; c++) begin
            rr  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            eol = (eol_cd == 0);
            if (eol_cd >= 0) eol_cd--;
            if (eol) eols++;
            pv = valid;
            px = x;
            py = y;
            if (pv && !rr) stalls_m++;
            tick();
            if (done) begin
                dones++;
                if (eols < P_LINES) early++;
                if (post < 0) post = 5;
            end
            if (pv && rr) begin
                grants++;
                if (int'(px) != exp_x || int'(py) != exp_y) seq_errs++;
                if (exp_x == P_LPL - 1) begin
                    exp_x  = 0;
                    eol_cd = (exp_y == P_LINES - 1) ? 10 : 2;
                    exp_y++;
                end else begin
                    exp_x++;
                end
            end else if (pv) begin
                if (!valid || x != px || y != py) hold_errs++;
            end
            if (stop_y >= 0 && valid && int'(y) == stop_y && int'(x) == stop_x) begin
                stopped = 1'b1;
                break;
            end
            if (post == 0) break;
            if (post > 0) post--;
        end
        eol = 1'b0;
        rr = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_grants"}, 32'(grants), 32'(P_LPL * P_LINES));
        check({tag, "_seq_errs"}, 32'(seq_errs), 0);
        check({tag, "_hold_errs"}, 32'(hold_errs), 0);
        check({tag, "_done_pulses"}, 32'(dones), 1);
        check({tag, "_done_before_last_eol"}, 32'(early), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        bit stopped;

        // start, lr, eol, rr | valid, busy, x, y
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd1, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd2, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'd2, 8'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd3, 8'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd4, 8'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd5, 8'd0};

        do_reset("reset0");

        // Start latency, ARM gating, held request under backpressure, start ignored while busy.
        for (int i = 0; i < 11; i++) begin
            start = vecs[i].start;
            lr    = vecs[i].lr;
            eol   = vecs[i].eol;
            rr    = vecs[i].rr;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_x", i), 32'(x), 32'(vecs[i].x));
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
        end
        start = 1'b0;
        rr = 1'b1;

        for (int i = 5; i < P_LPL - 1; i++) tick();
        check("line0_last_x", 32'(x), 32'(P_LPL - 1));
        tick();
        check("line0_wrap_valid", 32'(valid), 0);
        check("line0_wrap_x", 32'(x), 0);
        check("line0_wrap_y", 32'(y), 1);

        // Buffer full: park in ARM, then one cycle from ready to request.
        lr = 1'b0;
        ticks(10);
        check("park_valid", 32'(valid), 0);
        check("park_busy", 32'(busy), 1);
        lr = 1'b1;
        tick();
        check("line1_start_valid", 32'(valid), 1);
        check("line1_start_x", 32'(x), 0);
        check("line1_start_y", 32'(y), 1);

        ticks(P_LPL);
        check("line1_wrap_y", 32'(y), 2);

        // Two lines in flight and no EOL: ARM must hold until one EOL arrives.
        ticks(20);
        check("inflight_cap_valid", 32'(valid), 0);
        eol = 1'b1;
        tick();
        eol = 1'b0;
        check("eol_edge_valid", 32'(valid), 0);
        tick();
        check("eol_release_valid", 32'(valid), 1);
        check("eol_release_y", 32'(y), 2);

        eol = 1'b1;
        tick();
        eol = 1'b0;
        ticks(P_LPL - 1);
        check("line2_wrap_valid", 32'(valid), 0);
        check("line2_wrap_y", 32'(y), 3);

        // Settle length, load_ready ignored while settling, EOL coincident with arm at inflight 1.
        lr = 1'b0;
        ticks(3);
        lr = 1'b1;
        tick();
        check("settle_len_valid", 32'(valid), 0);
        eol = 1'b1;
        tick();
        eol = 1'b0;
        check("settle_exit_valid", 32'(valid), 1);
        check("settle_exit_x", 32'(x), 0);
        check("settle_exit_y", 32'(y), 3);

        ticks(P_LPL);
        ticks(5);
        check("coincident_next_arm_valid", 32'(valid), 1);
        check("coincident_next_arm_y", 32'(y), 4);
        ticks(P_LPL);
        ticks(10);
        check("coincident_cap_valid", 32'(valid), 0);
        check("coincident_cap_y", 32'(y), 5);

        // Spurious EOLs at inflight 0 must not underflow and close the gate.
        do_reset("reset1");
        eol = 1'b1;
        ticks(3);
        eol = 1'b0;
        lr = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sat_arm_valid", 32'(valid), 0);
        check("sat_arm_busy", 32'(busy), 1);
        tick();
        check("sat_first_req_valid", 32'(valid), 1);

        do_reset("reset2");
        run_frame(1'b0, -1, 0, stopped);
        check_frame("frame_full");

        do_reset("reset3");
        run_frame(1'b1, P_LINES / 2, P_LPL / 3, stopped);
        check("midframe_reached", 32'(stopped), 1);
        check("midframe_seq_errs", 32'(seq_errs), 0);
        check("midframe_hold_errs", 32'(hold_errs), 0);
`ifdef BICUBIC_SCHED_STATS_EN
        check("midframe_stall_cycles", stall, 32'(stalls_m));
`endif
        do_reset("reset_mid");
        run_frame(1'b1, -1, 0, stopped);
        check_frame("frame_random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
